// File: rtl/ram_ctrl.sv
// picorv32 native-bus controller for a 64 KiB RAM built from four byte-lane banks.
// Optional write protection of the window's low region is enabled by defining RAM_CTRL_WPROT_EN.
module ram_ctrl #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter logic [15:0] PROT_BYTES = 16'h1000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [13:0] ram_ad,
    output logic [31:0] ram_di,
    output logic [3:0]  ram_we,
    output logic [3:0]  ram_ce,
    input  logic [31:0] ram_do,
    output logic        wprot_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA, RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [13:0] r_ad;
    logic [31:0] r_di;
    logic [3:0]  r_we;
    logic [3:0]  r_ce;
    logic [31:0] r_rdata;
    logic        r_wr;
    logic        r_block;
    logic        w_sel;
    logic        w_start;
    logic        w_prot;
    logic        w_unused;

    assign w_sel   = (mem_addr[31:16] == BASE_ADDR[31:16]);
    // r_block masks the IDLE cycle right after RESP so a stale mem_valid is not reissued
    assign w_start = (r_state == IDLE) && mem_valid && w_sel && !mem_ready && !r_block;

`ifdef RAM_CTRL_WPROT_EN
    logic r_prot;

    assign w_prot    = (mem_wstrb != 4'h0) && (mem_addr[15:0] < PROT_BYTES);
    assign wprot_err = mem_ready & r_prot;
    assign w_unused  = ^mem_addr[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_prot <= 1'b0;
        end else if (w_start) begin
            r_prot <= w_prot;
        end
    end
`else
    assign w_prot    = 1'b0;
    assign wprot_err = 1'b0;
    assign w_unused  = ^{mem_addr[1:0], PROT_BYTES};
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = ACCESS;
            ACCESS:  w_next = r_wr ? RESP : RDATA;
            RDATA:   w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ad    <= 14'h0;
            r_di    <= 32'h0;
            r_we    <= 4'h0;
            r_ce    <= 4'h0;
            r_rdata <= 32'h0;
            r_wr    <= 1'b0;
            r_block <= 1'b0;
        end else begin
            r_ce    <= 4'h0;
            r_we    <= 4'h0;
            r_block <= (r_state == RESP);
            if (w_start) begin
                r_ad <= mem_addr[15:2];
                r_di <= mem_wdata;
                r_ce <= 4'hF;
                r_we <= w_prot ? 4'h0 : mem_wstrb;
                r_wr <= (mem_wstrb != 4'h0);
            end
            // banks present read data the cycle after enable, i.e. during RDATA
            if (r_state == RDATA) begin
                r_rdata <= ram_do;
            end
        end
    end

    assign mem_ready = (r_state == RESP);
    assign mem_rdata = r_rdata;
    assign ram_ad    = r_ad;
    assign ram_di    = r_di;
    assign ram_we    = r_we;
    assign ram_ce    = r_ce;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: byte-lane RAM banks, directed vector table, corner sequences
// and randomized traffic checked against a word-level shadow memory.
module tb_ram_ctrl;

`ifdef RAM_CTRL_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [13:0] ram_ad;
    logic [31:0] ram_di;
    logic [3:0]  ram_we;
    logic [3:0]  ram_ce;
    logic [31:0] ram_do = 32'h0;
    logic        wprot_err;

    int n_pass  = 0;
    int n_total = 0;

    ram_ctrl #(.BASE_ADDR(32'h0000_0000), .PROT_BYTES(16'h1000)) dut (
        .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .ram_ad(ram_ad), .ram_di(ram_di), .ram_we(ram_we),
        .ram_ce(ram_ce), .ram_do(ram_do), .wprot_err(wprot_err)
    );

    always #5 clk = ~clk;

    // four 8-bit banks sharing one word address
    logic [31:0] env_mem [0:16383] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++) begin
            if (ram_ce[l]) begin
                if (ram_we[l]) env_mem[ram_ad][8*l +: 8] <= ram_di[8*l +: 8];
                else           ram_do[8*l +: 8] <= env_mem[ram_ad][8*l +: 8];
            end
        end
    end

    // reference: what memory should contain and what the last read returned
    logic [31:0] shadow [0:16383] = '{default: 32'h0};
    logic [31:0] last_rd = 32'h0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic model_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output int lat, output logic [13:0] ad, output logic [3:0] we,
                             output logic [31:0] rd, output logic werr);
        logic blocked;
        ad      = a[15:2];
        blocked = PROT && (s != 4'h0) && (a[15:0] < 16'h1000);
        werr    = blocked;
        we      = blocked ? 4'h0 : s;
        if (s == 4'h0) begin
            lat     = 3;
            last_rd = shadow[ad];
        end else begin
            lat = 2;
            if (!blocked)
                for (int l = 0; l < 4; l++)
                    if (s[l]) shadow[ad][8*l +: 8] = d[8*l +: 8];
        end
        rd = last_rd;
    endtask

    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output int lat, output logic [13:0] ad, output logic [3:0] we,
                           output logic [3:0] ce, output logic [31:0] rd, output logic werr,
                           output logic rdy_after);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        @(posedge clk); #1;
        ad = ram_ad; we = ram_we; ce = ram_ce;
        mem_valid = 1'b0; mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
        lat = 1;
        while (!mem_ready && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = mem_rdata; werr = wprot_err;
        @(posedge clk); #1;
        rdy_after = mem_ready;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          lat;
        logic [13:0] ad;
        logic [3:0]  we;
        logic [31:0] rd;
        logic        werr;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int          lat, mlat;
        logic [13:0] ad, mad;
        logic [3:0]  we, mwe, ce;
        logic [31:0] rd, mrd, a, d;
        logic [3:0]  s;
        logic        werr, mwerr, rdy_after;
        logic        seen;
        logic [13:0] idx;
        logic [13:0] bases [4];

        tbl[0] = '{32'h0000_2000, 32'hDEADBEEF, 4'hF,    2, 14'h0800, 4'hF,    32'h0000_0000, 1'b0};
        tbl[1] = '{32'h0000_2000, 32'h0,        4'h0,    3, 14'h0800, 4'h0,    32'hDEADBEEF,  1'b0};
        tbl[2] = '{32'h0000_2000, 32'h0000_AB00, 4'b0010, 2, 14'h0800, 4'b0010, 32'hDEADBEEF,  1'b0};
        tbl[3] = '{32'h0000_2000, 32'h0,        4'h0,    3, 14'h0800, 4'h0,    32'hDEADABEF,  1'b0};
        tbl[4] = '{32'h0000_FFFC, 32'h12345678, 4'hF,    2, 14'h3FFF, 4'hF,    32'hDEADABEF,  1'b0};
        tbl[5] = '{32'h0000_FFFC, 32'h0,        4'h0,    3, 14'h3FFF, 4'h0,    32'h12345678,  1'b0};
        tbl[6] = '{32'h0000_1000, 32'h00CD_0000, 4'b0100, 2, 14'h0400, 4'b0100, 32'h12345678,  1'b0};
        tbl[7] = '{32'h0000_1000, 32'h0,        4'h0,    3, 14'h0400, 4'h0,    32'h00CD_0000, 1'b0};
        tbl[8] = '{32'h0000_0FFC, 32'hAAAA5555, 4'hF,    2, 14'h03FF, PROT ? 4'h0 : 4'hF,
                   32'h00CD_0000, PROT};
        tbl[9] = '{32'h0000_0FFC, 32'h0,        4'h0,    3, 14'h03FF, 4'h0,
                   PROT ? 32'h0 : 32'hAAAA5555, 1'b0};

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(mem_ready), 32'h0);
        chk("rst_ce",    32'(ram_ce),    32'h0);
        chk("rst_we",    32'(ram_we),    32'h0);
        chk("rst_ad",    32'(ram_ad),    32'h0);
        chk("rst_di",    ram_di,         32'h0);
        chk("rst_rdata", mem_rdata,      32'h0);
        chk("rst_werr",  32'(wprot_err), 32'h0);
        resetn = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, lat, ad, we, ce, rd, werr, rdy_after);
            model_txn(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, mlat, mad, mwe, mrd, mwerr);
            chk("vec_lat",   32'(lat),       32'(tbl[i].lat));
            chk("vec_ad",    32'(ad),        32'(tbl[i].ad));
            chk("vec_we",    32'(we),        32'(tbl[i].we));
            chk("vec_ce",    32'(ce),        32'hF);
            chk("vec_rdata", rd,             tbl[i].rd);
            chk("vec_werr",  32'(werr),      32'(tbl[i].werr));
            chk("vec_pulse", 32'(rdy_after), 32'h0);
        end

        // stale mem_valid held through RESP must not be accepted in the following IDLE cycle
        mem_valid = 1'b1; mem_addr = 32'h0000_2000; mem_wstrb = 4'h0;
        model_txn(32'h0000_2000, 32'h0, 4'h0, mlat, mad, mwe, mrd, mwerr);
        lat = 0;
        while (!mem_ready && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stale_lat", 32'(lat), 32'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stale_nostart", 32'(ram_ce), 32'h0);
        @(posedge clk); #1;
        chk("stale_restart", 32'(ram_ce), 32'hF);
        mem_valid = 1'b0;
        lat = 1;
        while (!mem_ready && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("stale_lat2", 32'(lat), 32'd3);
        chk("stale_rd", mem_rdata, mrd);
        repeat (2) @(posedge clk);
        #1;

        // reset while a read is in ACCESS
        mem_valid = 1'b1; mem_addr = 32'h0000_2000; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        resetn = 1'b0; mem_valid = 1'b0;
        @(posedge clk); #1;
        chk("rstacc_ready", 32'(mem_ready), 32'h0);
        chk("rstacc_ce",    32'(ram_ce),    32'h0);
        chk("rstacc_ad",    32'(ram_ad),    32'h0);
        chk("rstacc_di",    ram_di,         32'h0);
        chk("rstacc_rdata", mem_rdata,      32'h0);
        last_rd = 32'h0;
        resetn = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_ready) seen = 1'b1;
        end
        chk("rstacc_noack", 32'(seen), 32'h0);

        // out-of-window request is ignored
        mem_valid = 1'b1; mem_addr = 32'h0001_0000; mem_wstrb = 4'hF; mem_wdata = 32'h1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (mem_ready || ram_ce != 4'h0) seen = 1'b1;
        end
        mem_valid = 1'b0;
        chk("unsel_idle", 32'(seen), 32'h0);
        chk("unsel_rdata", mem_rdata, last_rd);
        @(posedge clk); #1;

        bases = '{14'h0000, 14'h03F0, 14'h0800, 14'h3FE0};
        for (int i = 0; i < 300; i++) begin
            idx = bases[$urandom_range(0, 3)] + 14'($urandom_range(0, 31));
            a   = {16'h0000, idx, 2'($urandom_range(0, 3))};
            d   = $urandom;
            s   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) begin
                a[31:16] = 16'($urandom_range(1, 16'hFFFF));
                mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
                seen = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    mem_valid = 1'b0;
                    if (mem_ready || ram_ce != 4'h0) seen = 1'b1;
                end
                chk("rnd_unsel", 32'(seen), 32'h0);
            end else begin
                run_txn(a, d, s, lat, ad, we, ce, rd, werr, rdy_after);
                model_txn(a, d, s, mlat, mad, mwe, mrd, mwerr);
                chk("rnd_lat",   32'(lat),       32'(mlat));
                chk("rnd_ad",    32'(ad),        32'(mad));
                chk("rnd_we",    32'(we),        32'(mwe));
                chk("rnd_rdata", rd,             mrd);
                chk("rnd_werr",  32'(werr),      32'(mwerr));
                chk("rnd_pulse", 32'(rdy_after), 32'h0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
